// File: rtl/result_unloader.sv
`timescale 1ns/1ps
// Drains 18-bit accumulated results from the result memory and streams them
// to the host as bytes, least-significant byte first, over valid/ready.
module result_unloader #(
   parameter int DATA_WIDTH = 8,
   parameter int m          = 8,
   parameter int n          = 8,
   parameter int WORD_WIDTH = 2*DATA_WIDTH+2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [m+n-1:0]        base_addr,
   input  logic [m+n-1:0]        word_count,
   output logic                  mem_en,
   output logic                  mem_rd_en,
   output logic [m+n-1:0]        mem_addr,
   input  logic [WORD_WIDTH-1:0] mem_data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int AW   = m + n;
   localparam int SH_W = 3 * DATA_WIDTH;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_SEND = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]      state_q,     state_d;
   logic [AW-1:0]   addr_q,      addr_d;
   logic [AW-1:0]   remaining_q, remaining_d;
   logic [SH_W-1:0] shift_q,     shift_d;
   logic [1:0]      byte_idx_q,  byte_idx_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      shift_d     = shift_q;
      byte_idx_d  = byte_idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d      = base_addr;
               remaining_d = word_count;
               state_d     = (word_count == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: begin
            shift_d    = SH_W'(mem_data);
            byte_idx_d = 2'd0;
            state_d    = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               if (byte_idx_q != 2'd2) begin
                  shift_d    = shift_q >> DATA_WIDTH;
                  byte_idx_d = byte_idx_q + 2'd1;
               end else begin
                  // remaining_q==1 means this handshake retires the final word
                  remaining_d = remaining_q - 1'b1;
                  addr_d      = addr_q + 1'b1;
                  state_d     = (remaining_q == AW'(1)) ? S_DONE : S_READ;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         shift_q     <= '0;
         byte_idx_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         shift_q     <= shift_d;
         byte_idx_q  <= byte_idx_d;
      end
   end

   // All outputs decode from registered state, so out_valid never sees out_ready
   always_comb begin
      mem_en    = (state_q == S_READ);
      mem_rd_en = (state_q == S_READ);
      mem_addr  = (state_q == S_READ) ? addr_q : '0;
      out_valid = (state_q == S_SEND);
      data_out  = (state_q == S_SEND) ? shift_q[DATA_WIDTH-1:0] : '0;
      busy      = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_SEND);
      done      = (state_q == S_DONE);
   end

endmodule
